// File: rtl/decode_sequencer.sv
// IF/ID pipeline controller: owns the IF/ID register, handles load-use stalls,
// memory freeze and wrong-path squashing after redirects, and counts stall cycles.
module decode_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        flush_cs,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        redirect,
  input  logic        mem_busy,
  output logic        freeze,
  output logic        bubble,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hazard;
  logic             load_beat;
  logic             kill_slot;
  logic             stall_evt;

  assign hazard = id_valid & ex_mem_read & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign stall_evt = ((state == RUN) & hazard) | mem_busy;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    load_beat   = 1'b0;
    kill_slot   = 1'b0;
    fetch_ready = 1'b0;
    bubble      = 1'b0;
    freeze      = mem_busy;
    // mem_busy freezes everything; any redirect is re-presented by EX later.
    if (!mem_busy) begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            fetch_ready = 1'b1;
            bubble      = 1'b1;
            kill_slot   = 1'b1;
            state_nxt   = FLUSH;
            cnt_nxt     = CNT_RELOAD;
          end else if (hazard) begin
            bubble = 1'b1;
          end else begin
            fetch_ready = 1'b1;
            bubble      = ~id_valid | flush_cs;
            load_beat   = fetch_valid;
            kill_slot   = ~fetch_valid;
          end
        end
        FLUSH: begin
          fetch_ready = 1'b1;
          bubble      = 1'b1;
          kill_slot   = 1'b1;
          if (redirect) begin
            cnt_nxt = CNT_RELOAD;
          end else if (cnt == '0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      id_pc        <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_beat) begin
        id_valid <= 1'b1;
        id_instr <= fetch_instr;
        id_pc    <= fetch_pc;
      end else if (kill_slot) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
      if (stall_evt && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer; a second instance with a one-cycle
// flush window shares the stimulus and is checked during the redirect scenario.
module tb_decode_sequencer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        flush_cs, ex_mem_read, redirect, mem_busy;

  logic        fetch_ready, id_valid, freeze, bubble;
  logic [31:0] id_instr, id_pc, stall_cycles;
  logic        fetch_ready_1, id_valid_1, freeze_1, bubble_1;
  logic [31:0] id_instr_1, id_pc_1, stall_cycles_1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_stall;
  logic [63:0] sb[$];
  logic [63:0] e;

  always #5 clk = ~clk;

  decode_sequencer #(.FLUSH_CYCLES(2), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .flush_cs(flush_cs), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .redirect(redirect), .mem_busy(mem_busy), .freeze(freeze), .bubble(bubble),
    .stall_cycles(stall_cycles)
  );

  decode_sequencer #(.FLUSH_CYCLES(1), .NOP_INSTR(NOP)) dut1 (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .fetch_ready(fetch_ready_1), .id_valid(id_valid_1),
    .id_instr(id_instr_1), .id_pc(id_pc_1), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .flush_cs(flush_cs), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .redirect(redirect), .mem_busy(mem_busy), .freeze(freeze_1), .bubble(bubble_1),
    .stall_cycles(stall_cycles_1)
  );

  task automatic idle_inputs();
    fetch_valid = 0; fetch_instr = '0; fetch_pc = '0;
    id_rs1 = 0; id_rs2 = 0; flush_cs = 0; ex_mem_read = 0; ex_rd = 0;
    redirect = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); mem_busy = 1;
    tick(); exp_stall = 1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL pre_reset_stall: got %0d expected %0d", stall_cycles, exp_stall); end
    @(negedge clk); mem_busy = 0; redirect = 1;
    tick();
    @(negedge clk); redirect = 0; rst = 1; #1;
    exp_stall = 0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL rst_id_instr: got %h expected %h", id_instr, NOP); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h expected 0", id_pc); end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stall_cycles); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b expected 0", freeze); end
    tick();
    @(negedge clk); rst = 0;
    fetch_valid = 1; fetch_instr = 32'hdead0001; fetch_pc = 32'h100;
    sb.push_back({fetch_instr, fetch_pc}); #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_run_ready: got %b expected 1", fetch_ready); end
    tick(); e = sb.pop_front();
    checks++; if (id_valid !== 1'b1 || {id_instr, id_pc} !== e) begin errors++; $display("FAIL rst_run_load: got v=%b %h expected v=1 %h", id_valid, {id_instr, id_pc}, e); end
  endtask

  task automatic test_stream();
    logic [63:0] beats[3];
    beats[0] = {32'h000600b7, 32'h0};
    beats[1] = {32'h00100113, 32'h4};
    beats[2] = {32'h002081b3, 32'h8};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs();
      fetch_valid = 1; {fetch_instr, fetch_pc} = beats[i];
      sb.push_back(beats[i]); #1;
      checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, fetch_ready); end
      tick(); e = sb.pop_front();
      checks++; if (id_valid !== 1'b1 || {id_instr, id_pc} !== e) begin errors++; $display("FAIL stream_id[%0d]: got v=%b %h expected v=1 %h", i, id_valid, {id_instr, id_pc}, e); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL stream_bubble[%0d]: got %b expected 0", i, bubble); end
    end
    @(negedge clk); flush_cs = 1; #1;
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL flush_cs_bubble: got %b expected 1", bubble); end
    @(negedge clk); idle_inputs();
    tick();
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin errors++; $display("FAIL empty_slot: got v=%b %h expected v=0 %h", id_valid, id_instr, NOP); end
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL empty_bubble: got %b expected 1", bubble); end
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle_inputs();
      fetch_valid = 1; fetch_instr = 32'h00a00093 + k; fetch_pc = 32'h40 + 32'(k * 8);
      sb.push_back({fetch_instr, fetch_pc});
      tick(); e = sb.pop_front();
      checks++; if ({id_instr, id_pc} !== e) begin errors++; $display("FAIL lu_setup[%0d]: got %h expected %h", k, {id_instr, id_pc}, e); end
      @(negedge clk);
      fetch_instr = 32'h0000b103 + k; fetch_pc = fetch_pc + 4;
      ex_mem_read = 1; ex_rd = 1;
      if (k == 0) id_rs1 = 1; else id_rs2 = 1;
      #1;
      checks++; if (fetch_ready !== 1'b0 || bubble !== 1'b1) begin errors++; $display("FAIL lu_stall[%0d]: got ready=%b bubble=%b expected ready=0 bubble=1", k, fetch_ready, bubble); end
      tick(); exp_stall = exp_stall + 1;
      checks++; if (id_valid !== 1'b1 || {id_instr, id_pc} !== e) begin errors++; $display("FAIL lu_hold[%0d]: got %h expected %h", k, {id_instr, id_pc}, e); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_count[%0d]: got %0d expected %0d", k, stall_cycles, exp_stall); end
      @(negedge clk); ex_mem_read = 0;
      sb.push_back({fetch_instr, fetch_pc}); #1;
      checks++; if (fetch_ready !== 1'b1 || bubble !== 1'b0) begin errors++; $display("FAIL lu_release[%0d]: got ready=%b bubble=%b expected ready=1 bubble=0", k, fetch_ready, bubble); end
      tick(); e = sb.pop_front();
      checks++; if ({id_instr, id_pc} !== e) begin errors++; $display("FAIL lu_next[%0d]: got %h expected %h", k, {id_instr, id_pc}, e); end
    end
  endtask

  task automatic test_rd_zero();
    @(negedge clk); idle_inputs();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    fetch_valid = 1; fetch_instr = 32'h00000033; fetch_pc = 32'h80;
    sb.push_back({fetch_instr, fetch_pc}); #1;
    checks++; if (fetch_ready !== 1'b1 || bubble !== 1'b0) begin errors++; $display("FAIL rd0_nostall: got ready=%b bubble=%b expected ready=1 bubble=0", fetch_ready, bubble); end
    tick(); e = sb.pop_front();
    checks++; if ({id_instr, id_pc} !== e || stall_cycles !== exp_stall) begin errors++; $display("FAIL rd0_load: got %h stall=%0d expected %h stall=%0d", {id_instr, id_pc}, stall_cycles, e, exp_stall); end
  endtask

  task automatic test_redirect();
    @(negedge clk); idle_inputs();
    redirect = 1; fetch_valid = 1; fetch_instr = 32'hbad00000; fetch_pc = 32'h200; #1;
    checks++; if (bubble !== 1'b1 || fetch_ready !== 1'b1) begin errors++; $display("FAIL redir_cycle: got bubble=%b ready=%b expected 1 1", bubble, fetch_ready); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin errors++; $display("FAIL redir_kill: got v=%b %h expected v=0 %h", id_valid, id_instr, NOP); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); redirect = 0;
      fetch_instr = 32'hbad00000 + i; fetch_pc = 32'h200 + 32'(i * 4); #1;
      checks++; if (bubble !== 1'b1 || fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_cycle[%0d]: got bubble=%b ready=%b expected 1 1", i, bubble, fetch_ready); end
      checks++; if (fetch_ready_1 !== 1'b1) begin errors++; $display("FAIL f1_ready[%0d]: got %b expected 1", i, fetch_ready_1); end
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: got %b expected 0", i, id_valid); end
      if (i == 1) begin
        checks++; if (id_valid_1 !== 1'b0) begin errors++; $display("FAIL f1_drop: got %b expected 0", id_valid_1); end
      end else begin
        checks++; if (id_valid_1 !== 1'b1 || id_instr_1 !== 32'hbad00002) begin errors++; $display("FAIL f1_load: got v=%b %h expected v=1 bad00002", id_valid_1, id_instr_1); end
      end
    end
    @(negedge clk); fetch_instr = 32'h00c00513; fetch_pc = 32'h300;
    sb.push_back({fetch_instr, fetch_pc}); #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL redir_resume_ready: got %b expected 1", fetch_ready); end
    tick(); e = sb.pop_front();
    checks++; if (id_valid !== 1'b1 || {id_instr, id_pc} !== e) begin errors++; $display("FAIL redir_resume: got v=%b %h expected v=1 %h", id_valid, {id_instr, id_pc}, e); end
    checks++; if (id_instr_1 !== 32'h00c00513) begin errors++; $display("FAIL f1_resume: got %h expected 00c00513", id_instr_1); end
  endtask

  task automatic test_freeze();
    @(negedge clk); idle_inputs(); redirect = 1;
    tick();
    @(negedge clk); redirect = 0; fetch_valid = 1; fetch_instr = 32'hbad10000;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_busy = 1; redirect = 1; #1;
      checks++; if (freeze !== 1'b1 || fetch_ready !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL frz_out[%0d]: got freeze=%b ready=%b bubble=%b expected 1 0 0", i, freeze, fetch_ready, bubble); end
      tick(); exp_stall = exp_stall + 1;
      checks++; if (id_valid !== 1'b0 || id_instr !== NOP || stall_cycles !== exp_stall) begin errors++; $display("FAIL frz_hold[%0d]: got v=%b %h stall=%0d expected v=0 %h stall=%0d", i, id_valid, id_instr, stall_cycles, NOP, exp_stall); end
    end
    @(negedge clk); mem_busy = 0; redirect = 0; fetch_instr = 32'hbad10001; #1;
    checks++; if (bubble !== 1'b1 || freeze !== 1'b0) begin errors++; $display("FAIL frz_flush_resume: got bubble=%b freeze=%b expected 1 0", bubble, freeze); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL frz_flush_drop: got %b expected 0", id_valid); end
    @(negedge clk); fetch_instr = 32'h00208233; fetch_pc = 32'h400;
    sb.push_back({fetch_instr, fetch_pc});
    tick(); e = sb.pop_front();
    checks++; if (id_valid !== 1'b1 || {id_instr, id_pc} !== e) begin errors++; $display("FAIL frz_after_load: got v=%b %h expected v=1 %h", id_valid, {id_instr, id_pc}, e); end
    @(negedge clk); mem_busy = 1; fetch_instr = 32'h11111111; fetch_pc = 32'h404; #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL frz_run_ready: got %b expected 0", fetch_ready); end
    tick(); exp_stall = exp_stall + 1;
    checks++; if ({id_instr, id_pc} !== e || stall_cycles !== exp_stall) begin errors++; $display("FAIL frz_run_hold: got %h stall=%0d expected %h stall=%0d", {id_instr, id_pc}, stall_cycles, e, exp_stall); end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1; exp_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    test_reset();
    test_stream();
    test_load_use();
    test_rd_zero();
    test_redirect();
    test_freeze();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
